// File: rtl/fpa_pkg.sv
// Shared widths, default adder latency and the tag carried alongside each operation.
package fpa_pkg;

    localparam int FP_W    = 32;
    localparam int FPA_LAT = 3;

    typedef struct packed {
        logic       valid;
        logic [3:0] id;
    } fpa_tag_t;

endpackage

// File: rtl/fp_add_sched_if.sv
// Requester and response bundle of fp_add_sched; req_sub exists only with FPA_SCHED_SUB_EN.
interface fp_add_sched_if #(parameter int NREQ = 4);
    import fpa_pkg::*;

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    logic [NREQ-1:0][FP_W-1:0] req_a;
    logic [NREQ-1:0][FP_W-1:0] req_b;
`ifdef FPA_SCHED_SUB_EN
    logic [NREQ-1:0]           req_sub;
`endif
    logic                      hold;
    logic                      rsp_valid;
    logic [IDW-1:0]            rsp_id;
    logic [FP_W-1:0]           rsp_data;
    logic                      busy;

    modport master (
        output req_valid, req_a, req_b, hold,
`ifdef FPA_SCHED_SUB_EN
        output req_sub,
`endif
        input  req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, hold,
`ifdef FPA_SCHED_SUB_EN
        input  req_sub,
`endif
        output req_ready, rsp_valid, rsp_id, rsp_data, busy
    );

endinterface

// File: rtl/fpa_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping.
module fpa_rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/fp_add_sched.sv
// Shares one pipelined fp_adder among NREQ requesters; a tag pipeline returns each result to its issuer.
// Optional FPA_SCHED_SUB_EN adds per-requester subtract (sign flip of B at issue).
module fp_add_sched
    import fpa_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int LAT  = FPA_LAT,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    fp_add_sched_if.slave    rq,
    output logic [FP_W-1:0]  fpa_a,
    output logic [FP_W-1:0]  fpa_b,
    input  logic [FP_W-1:0]  fpa_result
);

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [FP_W-1:0]  fpa_a_q, fpa_a_d;
    logic [FP_W-1:0]  fpa_b_q, fpa_b_d;
    fpa_tag_t [LAT:0] tag_q, tag_d;

    logic [NREQ-1:0]  gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             accept;
    logic             busy_c;
    logic             unused_id_bits;

    fpa_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (rq.req_valid),
        .ptr     (ptr_q),
        .en      (!rq.hold),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // The grant is already masked by hold and valid, so any bit set is an accept.
    assign rq.req_ready = gnt;
    assign accept       = |gnt;

    always_comb begin
        ptr_d   = ptr_q;
        fpa_a_d = '0;
        fpa_b_d = '0;
        tag_d   = '0;
        for (int k = 1; k <= LAT; k++) tag_d[k] = tag_q[k-1];
        if (accept) begin
            fpa_a_d = rq.req_a[gnt_idx];
`ifdef FPA_SCHED_SUB_EN
            fpa_b_d = {rq.req_b[gnt_idx][FP_W-1] ^ rq.req_sub[gnt_idx],
                       rq.req_b[gnt_idx][FP_W-2:0]};
`else
            fpa_b_d = rq.req_b[gnt_idx];
`endif
            tag_d[0].valid = 1'b1;
            tag_d[0].id    = 4'(gnt_idx);
            ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            fpa_a_q <= '0;
            fpa_b_q <= '0;
            tag_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            fpa_a_q <= fpa_a_d;
            fpa_b_q <= fpa_b_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        busy_c = 1'b0;
        for (int k = 0; k <= LAT; k++) busy_c = busy_c | tag_q[k].valid;
    end

    assign fpa_a        = fpa_a_q;
    assign fpa_b        = fpa_b_q;
    assign rq.busy      = busy_c;
    assign rq.rsp_valid = tag_q[LAT].valid;
    assign rq.rsp_id    = tag_q[LAT].id[IDW-1:0];
    // Adder output is garbage when no tag is live (it has no reset), so gate it.
    assign rq.rsp_data  = tag_q[LAT].valid ? fpa_result : '0;
    assign unused_id_bits = ^tag_q[LAT].id;

endmodule

// File: tb/tb_fp_add_sched.sv
// Bench for fp_add_sched: behavioural 3-stage adder, scoreboard of issued ops, directed scenarios.
module tb_fp_add_sched;

    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fpa_a, fpa_b, fpa_result;
    logic [31:0] ap [LAT];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    fp_add_sched_if #(.NREQ(NREQ)) rq();

    fp_add_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rq         (rq),
        .fpa_a      (fpa_a),
        .fpa_b      (fpa_b),
        .fpa_result (fpa_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic real s2r(input logic [31:0] s);
        if (s[30:23] == 8'd0) return 0.0;
        return $bitstoreal({s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic sub);
        return r2s(s2r(a) + s2r({b[31] ^ sub, b[30:0]}));
    endfunction

    // Adder model: result register LAT edges after its a/b inputs.
    always @(posedge clk) begin
        ap[0] <= r2s(s2r(fpa_a) + s2r(fpa_b));
        for (int k = 1; k < LAT; k++) ap[k] <= ap[k-1];
    end
    assign fpa_result = ap[LAT-1];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sub_of(input int i);
`ifdef FPA_SCHED_SUB_EN
        return rq.req_sub[i];
`else
        return 1'b0 & i[0];
`endif
    endfunction

    // Scoreboard: push on accept, pop and compare on every response.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (rq.rsp_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", 64'(1), 64'(0));
                end else begin
                    chk("rsp_id", 64'(rq.rsp_id), 64'(sbq[0].id));
                    chk("rsp_data", 64'(rq.rsp_data), 64'(sbq[0].data));
                    chk("rsp_latency", 64'(cyc - sbq[0].cyc), 64'(LAT + 1));
                    void'(sbq.pop_front());
                end
            end
            for (int i = 0; i < NREQ; i++)
                if (rq.req_valid[i] && rq.req_ready[i])
                    sbq.push_back('{i, fadd(rq.req_a[i], rq.req_b[i], sub_of(i)), cyc});
        end
    end

    initial begin
        logic [31:0] ta [NREQ];
        logic [31:0] tb [NREQ];
        int          n_rsp;
        int          k_end;
        logic        seen;
        ta = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        tb = '{32'h40000000, 32'h3F800000, 32'h3F000000, 32'h40A00000};

        rst_n        = 1'b0;
        rq.req_valid = '0;
        rq.req_a     = '0;
        rq.req_b     = '0;
        rq.hold      = 1'b0;
`ifdef FPA_SCHED_SUB_EN
        rq.req_sub   = '0;
`endif
        tick();
        tick();
        chk("rst_fpa_a", 64'(fpa_a), 64'(0));
        chk("rst_fpa_b", 64'(fpa_b), 64'(0));
        chk("rst_rsp_valid", 64'(rq.rsp_valid), 64'(0));
        chk("rst_busy", 64'(rq.busy), 64'(0));
        chk("rst_rsp_data", 64'(rq.rsp_data), 64'(0));
        rq.req_valid = 4'b1010;
        #1 chk("rst_ready_ptr0", 64'(rq.req_ready), 64'(4'b0010));
        rq.req_valid = '0;
        rst_n = 1'b1;
        tick();

        // Single op from requester 0: 1.0 + 2.0
        rq.req_a[0] = 32'h3F800000;
        rq.req_b[0] = 32'h40000000;
        rq.req_valid = 4'b0001;
        #1 chk("t1_ready", 64'(rq.req_ready), 64'(4'b0001));
        tick();
        rq.req_valid = '0;
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            if (rq.rsp_valid) begin
                seen = 1'b1;
                chk("t1_edges_after_accept", 64'(n), 64'(LAT));
                chk("t1_rsp_id", 64'(rq.rsp_id), 64'(0));
                chk("t1_rsp_data", 64'(rq.rsp_data), 64'(32'h40400000));
            end else begin
                tick();
            end
        end
        if (!seen) chk("t1_timeout", 64'(0), 64'(1));

        // Lone requester 3 with ptr=1: granted, ptr wraps to 0
        rq.req_a[3] = 32'h40800000;
        rq.req_b[3] = 32'h3F000000;
        rq.req_valid = 4'b1000;
        #1 chk("single_req3", 64'(rq.req_ready), 64'(4'b1000));
        tick();

        // All valid for 8 cycles from ptr=0
        for (int i = 0; i < NREQ; i++) begin
            rq.req_a[i] = ta[i];
            rq.req_b[i] = tb[i];
        end
        rq.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 chk("rr_order", 64'(rq.req_ready), 64'(4'b0001 << (k % 4)));
            tick();
        end
        rq.req_valid = '0;
        repeat (6) tick();

        // Requester 2 alone: first moves ptr to 3, then granted again with ptr=3
        rq.req_valid = 4'b0100;
        tick();
        #1 chk("req2_at_ptr3", 64'(rq.req_ready), 64'(4'b0100));
        tick();
        rq.req_valid = 4'b1111;
        #1 chk("ptr_after_req2", 64'(rq.req_ready), 64'(4'b1000));
        rq.req_valid = '0;
        #1;

        // Hold with 3 ops in flight
        rq.req_valid = 4'b1111;
        tick();
        tick();
        tick();
        rq.hold = 1'b1;
        #1 chk("hold_ready", 64'(rq.req_ready), 64'(0));
        chk("hold_busy", 64'(rq.busy), 64'(1));
        n_rsp = 0;
        k_end = -1;
        for (int k = 1; k <= 10 && k_end < 0; k++) begin
            tick();
            if (!rq.busy) k_end = k;
            else n_rsp += int'(rq.rsp_valid);
        end
        chk("hold_busy_fall_edge", 64'(k_end), 64'(LAT + 1));
        chk("hold_rsp_count", 64'(n_rsp), 64'(3));
        rq.req_valid = '0;
        rq.hold = 1'b0;

        // Reset with 2 ops in flight
        rq.req_valid = 4'b1111;
        tick();
        tick();
        rq.req_valid = 4'b0110;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_fpa_a", 64'(fpa_a), 64'(0));
        chk("mid_rst_fpa_b", 64'(fpa_b), 64'(0));
        chk("mid_rst_rsp_valid", 64'(rq.rsp_valid), 64'(0));
        chk("mid_rst_rsp_id", 64'(rq.rsp_id), 64'(0));
        chk("mid_rst_rsp_data", 64'(rq.rsp_data), 64'(0));
        chk("mid_rst_busy", 64'(rq.busy), 64'(0));
        chk("mid_rst_ready", 64'(rq.req_ready), 64'(4'b0010));
        rq.req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("post_rst_no_rsp", 64'(rq.rsp_valid), 64'(0));
        end

`ifdef FPA_SCHED_SUB_EN
        // 3.0 - 1.0
        rq.req_a[0]  = 32'h40400000;
        rq.req_b[0]  = 32'h3F800000;
        rq.req_sub   = 4'b0001;
        rq.req_valid = 4'b0001;
        tick();
        rq.req_valid = '0;
        seen = 1'b0;
        for (int n = 0; n < 8 && !seen; n++) begin
            if (rq.rsp_valid) begin
                seen = 1'b1;
                chk("sub_rsp_data", 64'(rq.rsp_data), 64'(32'h40000000));
            end else begin
                tick();
            end
        end
        if (!seen) chk("sub_timeout", 64'(0), 64'(1));
        rq.req_sub = '0;
`endif

        repeat (6) tick();
        chk("scoreboard_drained", 64'(sbq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
